// File: rtl/stream_delay_pkg.sv
// Purpose: shared types, constants and register macro for the stream delay line.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: delay_mode_e, default LFSR seed, delay_t, LFSR step function, STREAM_DELAY_FF.

`ifndef STREAM_DELAY_FF
// Flop with asynchronous active-low reset; expects clk_i / rst_ni in scope.
`define STREAM_DELAY_FF(q, d, rst_val) \
  always_ff @(posedge clk_i or negedge rst_ni) begin \
    if (!rst_ni) q <= (rst_val); \
    else         q <= (d); \
  end
`endif

package stream_delay_pkg;

  typedef enum logic [0:0] {
    DelayFixed  = 1'b0,
    DelayRandom = 1'b1
  } delay_mode_e;

  localparam logic [15:0] DefaultLfsrSeed = 16'hACE1;

  // Delays are at most 255 cycles, so 8 bits cover every counter.
  localparam int unsigned DelayW = 8;
  typedef logic [DelayW-1:0] delay_t;

  // 16-bit Galois LFSR, taps 16,14,13,11 (right-shifting form, mask 0xB400).
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/stream_delay_lfsr.sv
// Purpose: per-beat delay generator (fixed value or LFSR-derived random value).
// Latency: delay_o is combinational from the current LFSR state; state advances on en_i.
// Backpressure: none; the caller pulses en_i once per accepted beat.
// Ports: clk_i, rst_ni (async active-low), clr_i (sync reseed), en_i (advance), delay_o.

module stream_delay_lfsr
  import stream_delay_pkg::*;
#(
  parameter delay_mode_e Mode     = DelayFixed,
  parameter int unsigned MinDelay = 1,
  parameter int unsigned MaxDelay = 1,
  parameter logic [15:0] LfsrSeed = DefaultLfsrSeed
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   clr_i,
  input  logic   en_i,
  output delay_t delay_o
);

  // Span of random offsets; collapses to 1 when the range is degenerate so
  // that K becomes 0 and the offset mask is empty.
  localparam int unsigned Span = (Mode == DelayRandom && MaxDelay > MinDelay) ?
                                 (MaxDelay - MinDelay + 1) : 1;
  localparam int unsigned K    = $clog2(Span);
  localparam logic [15:0] Mask = 16'((1 << K) - 1);

  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  rand_sum;

  always_comb begin
    lfsr_d = lfsr_q;
    if (clr_i) begin
      lfsr_d = LfsrSeed;
    end else if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  `STREAM_DELAY_FF(lfsr_q, lfsr_d, LfsrSeed)

  // A K-bit offset can overshoot a non power-of-two span; saturate at MaxDelay.
  always_comb begin
    rand_sum = 9'(MinDelay) + 9'(lfsr_q & Mask);
    delay_o  = delay_t'(MinDelay);
    if (Mode == DelayRandom) begin
      if (rand_sum > 9'(MaxDelay)) begin
        delay_o = delay_t'(MaxDelay);
      end else begin
        delay_o = rand_sum[7:0];
      end
    end
  end

endmodule

// File: rtl/stream_delay_line.sv
// Purpose: in-order valid/ready delay line; each beat is held for a fixed or random delay.
// Latency: a beat accepted at edge t shows valid_o in cycle t+D (D = 1 means the next cycle).
// Backpressure: ready_o = not full (state only, no path from ready_i); valid_o/payload_o hold until ready_i.
// Ports: clk_i, rst_ni, clr_i | valid_i, ready_o, payload_i | valid_o, ready_i, payload_o | usage_o.

module stream_delay_line
  import stream_delay_pkg::*;
#(
  parameter type         payload_t = logic,
  parameter int unsigned Depth     = 4,
  parameter delay_mode_e Mode      = DelayFixed,
  parameter int unsigned MinDelay  = 1,
  parameter int unsigned MaxDelay  = 1,
  parameter logic [15:0] LfsrSeed  = DefaultLfsrSeed,
  localparam int unsigned UsageW   = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  payload_t          payload_i,
  output logic              valid_o,
  input  logic              ready_i,
  output payload_t          payload_o,
  output logic [UsageW-1:0] usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  if (Depth < 1 || Depth > 16) begin : g_bad_depth
    $error("stream_delay_line: Depth must be in 1..16");
  end
  if (MinDelay < 1 || MinDelay > 255) begin : g_bad_min
    $error("stream_delay_line: MinDelay must be in 1..255");
  end
  if (Mode == DelayRandom && (MaxDelay < MinDelay || MaxDelay > 255)) begin : g_bad_max
    $error("stream_delay_line: MaxDelay must be in MinDelay..255");
  end
  if (LfsrSeed == 16'h0000) begin : g_bad_seed
    $error("stream_delay_line: LfsrSeed must be non-zero");
  end

  payload_t          mem_q [Depth];
  payload_t          mem_d [Depth];
  delay_t            cnt_q [Depth];
  delay_t            cnt_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [UsageW-1:0] usage_q, usage_d;
  logic              push, pop;
  delay_t            delay;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  stream_delay_lfsr #(
    .Mode     (Mode),
    .MinDelay (MinDelay),
    .MaxDelay (MaxDelay),
    .LfsrSeed (LfsrSeed)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .en_i    (push),
    .delay_o (delay)
  );

  assign ready_o   = (usage_q < UsageW'(Depth));
  // Only the head may leave; an expired younger entry waits behind it.
  assign valid_o   = (usage_q != '0) && (cnt_q[rd_ptr_q] == '0);
  assign payload_o = mem_q[rd_ptr_q];
  assign usage_o   = usage_q;

  // Clear wins over both handshakes: the cycle's input beat is dropped.
  assign push = valid_i && ready_o && !clr_i;
  assign pop  = valid_o && ready_i && !clr_i;

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      mem_d[i] = mem_q[i];
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - delay_t'(1) : '0;
    end
    if (push) begin
      // Counter holds D-1 so that D = 1 is visible right after acceptance.
      mem_d[wr_ptr_q] = payload_i;
      cnt_d[wr_ptr_q] = delay - delay_t'(1);
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    usage_d = usage_q;
    if (push && !pop) begin
      usage_d = usage_q + UsageW'(1);
    end else if (!push && pop) begin
      usage_d = usage_q - UsageW'(1);
    end

    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end
  end

  for (genvar i = 0; i < Depth; i++) begin : g_entry
    `STREAM_DELAY_FF(mem_q[i], mem_d[i], '0)
    `STREAM_DELAY_FF(cnt_q[i], cnt_d[i], '0)
  end

  `STREAM_DELAY_FF(wr_ptr_q, wr_ptr_d, '0)
  `STREAM_DELAY_FF(rd_ptr_q, rd_ptr_d, '0)
  `STREAM_DELAY_FF(usage_q,  usage_d,  '0)

`ifndef SYNTHESIS
  // A presented beat must stay put until it is taken.
  hold_until_ready : assert property (
    @(posedge clk_i) disable iff (!rst_ni || clr_i)
    (valid_o && !ready_i) |=> (valid_o && $stable(payload_o))
  );
`endif

endmodule
